// File: rtl/fpu_mul_pkg.sv
// Constants and types shared by the mantissa multiplier, its final
// carry-propagate resolver and the normaliser.
package fpu_mul_pkg;

   localparam int MANT_PROD_W = 48;
   localparam int MUL_CHUNK_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } resolver_state_e;

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational CHUNK-bit ripple adder used by the final resolver, plus the
// one-bit full-adder cell it is built from.
module FullAdder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module csa_chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);
   logic [CHUNK:0] w_c;

   assign w_c[0] = cin;

   for (genvar g = 0; g < CHUNK; g++) begin : g_bit
      FullAdder u_fa (
         .a    (a[g]),
         .b    (b[g]),
         .cin  (w_c[g]),
         .sum  (sum[g]),
         .cout (w_c[g+1])
      );
   end

   assign cout = w_c[CHUNK];
endmodule

// File: rtl/csa_final_resolver.sv
// Resolves the redundant sum/carry pair from the CSA tree into one binary
// product, CHUNK bits per clock, behind valid/ready on both sides.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | waiting for operands, InReady=1
//   ST_ADD  | rippling chunk k of A+B into Product
//   ST_DONE | result presented, OutValid=1 until OutReady
module csa_final_resolver
   import fpu_mul_pkg::*;
#(
   parameter int WIDTH = MANT_PROD_W,
   parameter int CHUNK = MUL_CHUNK_W
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] SumVec,
   input  logic [WIDTH-1:0] CarryVec,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Product,
   output logic             Overflow
);

   if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("csa_final_resolver: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
   end

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   resolver_state_e r_state;
   resolver_state_e w_state_nxt;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_msb;
   logic [KW-1:0]    r_k;
   logic             r_c;
   logic [WIDTH-1:0] r_prod;
   logic             r_ovf;

   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CHUNK-1:0] w_sum;
   logic             w_cout;
   logic             w_last;

   assign w_a_chunk = r_a[r_k*CHUNK +: CHUNK];
   assign w_b_chunk = r_b[r_k*CHUNK +: CHUNK];
   assign w_last    = (r_k == KW'(NCHUNK-1));

   csa_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .a    (w_a_chunk),
      .b    (w_b_chunk),
      .cin  (r_c),
      .sum  (w_sum),
      .cout (w_cout)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake outputs depend on the state register alone.
   always_comb begin
      w_state_nxt = r_state;
      InReady     = 1'b0;
      OutValid    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            InReady = 1'b1;
            if (InValid) w_state_nxt = ST_ADD;
         end
         ST_ADD: begin
            if (w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            OutValid = 1'b1;
            if (OutReady) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_msb  <= 1'b0;
         r_k    <= '0;
         r_c    <= 1'b0;
         r_prod <= '0;
         r_ovf  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (InValid) begin
                  // Carry bit i weighs 2^(i+1); its top bit falls off the
                  // product and can only contribute to overflow.
                  r_a    <= SumVec;
                  r_b    <= {CarryVec[WIDTH-2:0], 1'b0};
                  r_msb  <= CarryVec[WIDTH-1];
                  r_k    <= '0;
                  r_c    <= 1'b0;
                  r_prod <= '0;
                  r_ovf  <= 1'b0;
               end
            end
            ST_ADD: begin
               r_prod[r_k*CHUNK +: CHUNK] <= w_sum;
               r_c                        <= w_cout;
               if (w_last) begin
                  r_ovf <= w_cout | r_msb;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign Product  = r_prod;
   assign Overflow = r_ovf;

endmodule

// File: doc/csa_final_resolver.md
# csa_final_resolver

Final carry-propagate stage of the mantissa multiplier. Accepts the redundant sum/carry vectors left by the carry-save reduction tree and resolves them into one binary product, CHUNK bits per clock, behind valid/ready handshakes on both sides. It sits between the last compression stage and the normaliser. It trades a short multi-cycle latency for a narrow ripple adder.

## Interface
- WIDTH, 48: width of SumVec, CarryVec and Product (24x24 mantissa product).
- CHUNK, 8: bits resolved per cycle. WIDTH % CHUNK must be 0 and CHUNK must be ≥ 1; any other value is an elaboration error.
- Derived: NCHUNK = WIDTH/CHUNK (default 6).

Ports:
- Clk  in  1  rising-edge clock; the only clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- InValid  in  1  SumVec/CarryVec are valid.
- InReady  out  1  block can accept operands.
- SumVec  in  WIDTH  sum vector from the tree, bit i has weight 2^i.
- CarryVec  in  WIDTH  carry vector, unshifted: bit i has weight 2^(i+1).
- OutValid  out  1  Product/Overflow are valid.
- OutReady  in  1  downstream accepts the result.
- Product  out  WIDTH  (SumVec + 2·CarryVec) mod 2^WIDTH.
- Overflow  out  1  true sum ≥ 2^WIDTH.

## Operation
- States:
  - IDLE: InReady=1, OutValid=0.
  - ADD: InReady=0, OutValid=0.
  - DONE: InReady=0, OutValid=1.
- IDLE → ADD on InValid&InReady at a clock edge. On that edge:
  - capture A=SumVec and B={CarryVec[WIDTH-2:0],1'b0};
  - capture MsbOut=CarryVec[WIDTH-1];
  - clear the chunk counter k, the chunk carry, Product and Overflow.
- ADD, each edge:
  - Product[k·CHUNK +: CHUNK] ← A chunk k + B chunk k + chunk carry;
  - chunk carry ← carry-out of that addition;
  - k ← k+1.
- ADD → DONE on the edge that processes k=NCHUNK-1. On that edge Overflow ← final carry-out | MsbOut.
- DONE → IDLE on the edge where OutReady=1. Product and Overflow stay stable and unchanged for as long as OutValid=1.
- InValid is ignored outside IDLE. No operand is queued.
- InReady and OutValid are decoded from the state register only and have no combinational path from inputs.

## Timing
- Reset (Rst_n low, asynchronous): state=IDLE, k=0, chunk carry=0, Product=0, Overflow=0, OutValid=0, InReady=1. Inputs are not sampled while Rst_n is low.
- Reset in ADD or DONE discards the operation immediately. The result is never presented.
- Latency: OutValid rises NCHUNK edges after the accepting edge (6 by default).
- Minimum initiation interval: NCHUNK+2 cycles (8 by default). This assumes OutReady is held high.
- Back-pressure: with OutReady=0 the block stays in DONE indefinitely and outputs hold.
- Wrap-around: the k counter never wraps. It is reloaded to 0 on every accept.

## Structure
- Shared package fpu_mul_pkg holds:
  - MANT_PROD_W=48 and MUL_CHUNK_W=8;
  - the resolver state enum (IDLE/ADD/DONE).
- The multiplier top and the normaliser import the same constants.
- One sub-module, csa_chunk_adder: a CHUNK-bit ripple adder built from the existing FullAdder cell. Inputs are a, b and cin; outputs are sum and cout. It is purely combinational. The FSM, counter and registers live in csa_final_resolver.

## Test plan
All cases use WIDTH=48, CHUNK=8.
- Sum=0x000000000001, Carry=0x000000000001 → Product=0x000000000003, Overflow=0, OutValid exactly 6 edges after accept.
- Full carry chain: Sum=0xFFFFFFFFFFFF, Carry=0x000000000001 → Product=0x000000000001, Overflow=1.
- Shifted-out MSB: Sum=0, Carry=0x800000000000 → Product=0, Overflow=1.
- Back-pressure: OutReady=0 for 10 cycles in DONE with InValid=1 and new operands driven:
  - OutValid, Product and Overflow hold; InReady stays 0; the new operands are not captured;
  - after OutReady=1, the next accept happens 2 edges later.
- Reset mid-ADD after chunk 2: Rst_n pulsed low between edges → immediately OutValid=0, Product=0, InReady=1. After release, Sum=0x123456789ABC, Carry=0x000000000010 → Product=0x123456789ADC.
- 10k random operand pairs with OutReady=1 and InValid=1 back-to-back:
  - compare against the model (Sum+2·Carry) mod 2^48 plus the overflow bit;
  - accepts occur every 8 cycles.
